// File: rtl/sfifo_pkg.sv
// Shared FIFO constants and beat type for the synchronous FIFO and its
// read/write side engines.
package sfifo_pkg;

  localparam int SFIFO_DW     = 16;
  localparam int SFIFO_DEPTH  = 16;
  localparam int SFIFO_ADDR_W = $clog2(SFIFO_DEPTH);

  typedef struct packed {
    logic [SFIFO_DW-1:0] data;
    logic                last;
  } beat_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry registered valid/ready buffer: head drives the stream output,
// tail absorbs one extra word so a capture and a pop can share a cycle.
module stream_skid2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);

  logic [1:0]        occ_p1;
  logic [DATA_W-1:0] head_p1;
  logic [DATA_W-1:0] tail_p1;

  // Buffer register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_p1  <= 2'd0;
      head_p1 <= '0;
    end else if (clr) begin
      occ_p1 <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_p1 == 2'd0) head_p1 <= push_data;
          else                tail_p1 <= push_data;
          occ_p1 <= occ_p1 + 2'd1;
        end
        2'b01: begin
          head_p1 <= tail_p1;
          occ_p1  <= occ_p1 - 2'd1;
        end
        2'b11: begin
          if (occ_p1 == 2'd1) begin
            head_p1 <= push_data;
          end else begin
            head_p1 <= tail_p1;
            tail_p1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ  = occ_p1;
  assign head = head_p1;

endmodule

// File: rtl/sfifo_rd_stream.sv
// Read-side drain engine: pops the FIFO, absorbs its one-cycle read latency
// and presents the words as a burst-framed valid/ready stream.
module sfifo_rd_stream
  import sfifo_pkg::*;
#(
  parameter int DW        = SFIFO_DW,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  input  logic          fifo_udfl,
  input  logic          flush,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          err_udfl
);

  logic [1:0]       occ;
  logic             vld_p1;
  logic [CNT_W-1:0] beat_cnt;
  logic             pop;
  logic [2:0]       inflight;

  assign pop      = m_valid & m_ready;
  assign inflight = {1'b0, occ} + {2'b00, vld_p1};
  // Words already buffered or in flight, less the one leaving now, must
  // leave room for the word this pop will return.
  assign fifo_rd  = !rst && !flush && !fifo_empty &&
                    (inflight < (3'd2 + {2'b00, pop}));
  assign m_valid  = (occ != 2'd0);
  assign m_last   = m_valid && (beat_cnt == CNT_W'(BURST_LEN - 1));

  // Read-latency stage: vld_p1 marks fifo_dout as holding a popped word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      beat_cnt <= '0;
      err_udfl <= 1'b0;
    end else begin
      vld_p1 <= fifo_rd;
      if (flush)
        beat_cnt <= '0;
      else if (pop)
        beat_cnt <= m_last ? '0 : beat_cnt + CNT_W'(1);
      if (fifo_udfl && fifo_rd)
        err_udfl <= 1'b1;
    end
  end

  stream_skid2 #(.DATA_W(DW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (vld_p1),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data)
  );

endmodule
